// File: rtl/elbeth_lsu.sv
// Load/store unit between the EXS stage and the data-memory port.
// One request in flight: IDLE accepts, BUSY holds the bus strobe until the memory
// answers (or the timeout expires), RESP emits a single done or exception pulse.
module elbeth_lsu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exs_req,
  input  logic                exs_we,
  input  logic [XLEN-1:0]     exs_addr,
  input  logic [XLEN-1:0]     exs_w_data,
  input  logic [1:0]          exs_size,
  input  logic                exs_signed,
  input  logic                exs_kill,
  output logic [XLEN-1:0]     dmem_addr,
  output logic                dmem_en,
  output logic [XLEN/8-1:0]   dmem_wr,
  output logic [XLEN-1:0]     dmem_w_data,
  input  logic [XLEN-1:0]     dmem_r_data,
  input  logic                dmem_ready,
  input  logic                dmem_error,
  output logic                lsu_stall,
  output logic                lsu_done,
  output logic [XLEN-1:0]     lsu_rd_data,
  output logic                lsu_exc,
  output logic [1:0]          lsu_exc_code,
  output logic [XLEN-1:0]     lsu_exc_addr
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  localparam logic [1:0] ExcMisaligned = 2'b01;
  localparam logic [1:0] ExcBus        = 2'b10;
  localparam logic [1:0] ExcTimeout    = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                 state_q;
  logic [TIMEOUT_W-1:0]   cnt_q;
  logic                   kill_q;
  logic [1:0]             size_q;
  logic                   signed_q;
  logic                   we_q;

  logic                   accept;
  logic                   misaligned;
  logic [OFFW-1:0]        off;
  logic [NB-1:0]          lanes;
  logic [XLEN-1:0]        w_rep;
  logic [XLEN-1:0]        r_shift;
  logic [XLEN-1:0]        load_ext;
  logic                   timeout_hit;
  logic                   kill_now;

  assign accept      = exs_req & ~exs_kill;
  assign off         = exs_addr[OFFW-1:0];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_W'(TIMEOUT - 1));
  // A kill in the exit cycle itself must still suppress the response pulse.
  assign kill_now    = kill_q | exs_kill;

  assign lsu_stall = ((state_q == StIdle) & accept & ~misaligned) | (state_q == StBusy);

  // Alignment check: address must be a multiple of the access size; dword needs XLEN=64.
  always_comb begin
    case (exs_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = exs_addr[0];
      2'b10:   misaligned = |exs_addr[1:0];
      default: misaligned = (XLEN == 32) || (|exs_addr[2:0]);
    endcase
  end

  // Byte-lane enables: 2**size consecutive lanes starting at the byte offset.
  always_comb begin
    int nbytes;
    nbytes = 1 << exs_size;
    lanes  = '0;
    for (int j = 0; j < int'(NB); j++) begin
      if (j >= int'(off) && j < int'(off) + nbytes) lanes[j] = 1'b1;
    end
  end

  // Store data replicated so the right bytes appear on whichever lanes are enabled.
  always_comb begin
    case (exs_size)
      2'b00:   w_rep = {NB{exs_w_data[7:0]}};
      2'b01:   w_rep = {(XLEN/16){exs_w_data[15:0]}};
      2'b10:   w_rep = {(XLEN/32){exs_w_data[31:0]}};
      default: w_rep = exs_w_data;
    endcase
  end

  // Load alignment and extension using the latched offset, size and signedness.
  always_comb begin
    r_shift = dmem_r_data >> {dmem_addr[OFFW-1:0], 3'b000};
    case (size_q)
      2'b00:   load_ext = signed_q ? XLEN'($signed(r_shift[7:0]))  : XLEN'(r_shift[7:0]);
      2'b01:   load_ext = signed_q ? XLEN'($signed(r_shift[15:0])) : XLEN'(r_shift[15:0]);
      2'b10:   load_ext = signed_q ? XLEN'($signed(r_shift[31:0])) : XLEN'(r_shift[31:0]);
      default: load_ext = r_shift;
    endcase
  end

  // Request FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      dmem_addr    <= '0;
      dmem_en      <= 1'b0;
      dmem_wr      <= '0;
      dmem_w_data  <= '0;
      lsu_done     <= 1'b0;
      lsu_rd_data  <= '0;
      lsu_exc      <= 1'b0;
      lsu_exc_code <= 2'b00;
      lsu_exc_addr <= '0;
    end else begin
      lsu_done    <= 1'b0;
      lsu_exc     <= 1'b0;
      lsu_rd_data <= '0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (misaligned) begin
              // Rejected before reaching the bus; EXS is not stalled.
              lsu_exc      <= 1'b1;
              lsu_exc_code <= ExcMisaligned;
              lsu_exc_addr <= exs_addr;
            end else begin
              dmem_addr   <= exs_addr;
              dmem_en     <= 1'b1;
              dmem_wr     <= exs_we ? lanes : '0;
              dmem_w_data <= w_rep;
              size_q      <= exs_size;
              signed_q    <= exs_signed;
              we_q        <= exs_we;
              cnt_q       <= '0;
              kill_q      <= 1'b0;
              state_q     <= StBusy;
            end
          end
        end
        StBusy: begin
          if (dmem_error || dmem_ready || timeout_hit) begin
            dmem_en <= 1'b0;
            dmem_wr <= '0;
            state_q <= StResp;
            if (dmem_error) begin
              lsu_exc      <= ~kill_now;
              lsu_exc_code <= ExcBus;
              lsu_exc_addr <= dmem_addr;
            end else if (dmem_ready) begin
              lsu_done    <= ~kill_now;
              lsu_rd_data <= (we_q || kill_now) ? '0 : load_ext;
            end else begin
              lsu_exc      <= ~kill_now;
              lsu_exc_code <= ExcTimeout;
              lsu_exc_addr <= dmem_addr;
            end
          end else begin
            cnt_q  <= cnt_q + TIMEOUT_W'(1);
            kill_q <= kill_now;
          end
        end
        StResp: begin
          kill_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
